// File: rtl/fic_seq_pkg.sv
// Shared definitions for the FIC loop-counter sequencer: state encoding,
// operation codes and the registered control-strobe bundle.
package fic_seq_pkg;

    localparam int unsigned WIDTH_DEF    = 6;
    localparam int unsigned NORM_MAX_DEF = 39;

    localparam logic OP_ALIGN = 1'b0;
    localparam logic OP_NORM  = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        STEP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic fic_load;
        logic fic_clr;
        logic fic_dec;
        logic fic_inc;
        logic shr;
        logic shl;
        logic done;
        logic busy;
    } ctl_t;

    // Strobe pattern owned by a given state; only the state and the captured op matter.
    function automatic ctl_t ctl_decode(input state_t st, input logic op);
        ctl_t c;
        c = '0;
        case (st)
            LOAD: begin
                c.fic_load = (op == OP_ALIGN);
                c.fic_clr  = (op == OP_NORM);
            end
            STEP: begin
                c.shr     = (op == OP_ALIGN);
                c.fic_dec = (op == OP_ALIGN);
                c.shl     = (op == OP_NORM);
                c.fic_inc = (op == OP_NORM);
            end
            DONE:    c.done = 1'b1;
            default: c = '0;
        endcase
        c.busy = (st != IDLE);
        return c;
    endfunction

endpackage

// File: rtl/fic_seq_if.sv
// Signal bundle between AWP control / FIC / shifter (master) and the sequencer (slave).
interface fic_seq_if
    import fic_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) ();

    logic             start;
    logic             op;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] fic_val;
    logic             norm_ok;
    logic             m_zero;

    logic             fic_load;
    logic [WIDTH-1:0] fic_in;
    logic             fic_clr;
    logic             fic_dec;
    logic             fic_inc;
    logic             shr;
    logic             shl;
    logic             busy;
    logic             done;
    logic             zero;
    logic             limit;

    modport master (
        output start, op, cnt, fic_val, norm_ok, m_zero,
        input  fic_load, fic_in, fic_clr, fic_dec, fic_inc, shr, shl,
        input  busy, done, zero, limit
    );

    modport slave (
        input  start, op, cnt, fic_val, norm_ok, m_zero,
        output fic_load, fic_in, fic_clr, fic_dec, fic_inc, shr, shl,
        output busy, done, zero, limit
    );

endinterface

// File: rtl/fic_seq.sv
// FIC loop sequencer: runs ALIGN (shift right by count) and NORM (shift left
// until normalized) by loading, clearing and stepping the external FIC counter.
module fic_seq
    import fic_seq_pkg::*;
#(
    parameter int unsigned      WIDTH    = WIDTH_DEF,
    parameter logic [WIDTH-1:0] NORM_MAX = WIDTH'(NORM_MAX_DEF)
) (
    input logic      clk_sys,
    input logic      rst,
    fic_seq_if.slave bus
);

    state_t           state;
    state_t           state_next;
    logic             op_q;
    logic             op_next;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_next;
    logic             zero_q;
    logic             zero_next;
    logic             limit_q;
    logic             limit_next;
    ctl_t             ctl_q;
    ctl_t             ctl_next;

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= OP_ALIGN;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            limit_q <= 1'b0;
            ctl_q   <= '0;
        end else begin
            state   <= state_next;
            op_q    <= op_next;
            cnt_q   <= cnt_next;
            zero_q  <= zero_next;
            limit_q <= limit_next;
            ctl_q   <= ctl_next;
        end
    end

    // Strobes are decoded from the next state so every output leaves a flop.
    always_comb begin
        state_next = state;
        op_next    = op_q;
        cnt_next   = cnt_q;
        zero_next  = zero_q;
        limit_next = limit_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = LOAD;
                    op_next    = bus.op;
                    cnt_next   = bus.cnt;
                    zero_next  = 1'b0;
                    limit_next = 1'b0;
                end
            end
            LOAD: state_next = CHECK;
            CHECK: begin
                if (op_q == OP_ALIGN) begin
                    state_next = (bus.fic_val == '0) ? DONE : STEP;
                end else if (bus.m_zero) begin
                    zero_next  = 1'b1;
                    state_next = DONE;
                end else if (bus.norm_ok) begin
                    state_next = DONE;
                end else if (bus.fic_val == NORM_MAX) begin
                    limit_next = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = STEP;
                end
            end
            STEP:    state_next = CHECK;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        ctl_next = ctl_decode(state_next, op_next);
    end

    assign bus.fic_load = ctl_q.fic_load;
    assign bus.fic_clr  = ctl_q.fic_clr;
    assign bus.fic_dec  = ctl_q.fic_dec;
    assign bus.fic_inc  = ctl_q.fic_inc;
    assign bus.shr      = ctl_q.shr;
    assign bus.shl      = ctl_q.shl;
    assign bus.done     = ctl_q.done;
    assign bus.busy     = ctl_q.busy;
    assign bus.fic_in   = cnt_q;
    assign bus.zero     = zero_q;
    assign bus.limit    = limit_q;

endmodule

// File: tb/tb_fic_seq.sv
// Bench for fic_seq: FIC counter and 48-bit mantissa models around the DUT,
// expected results derived from shift counts and cycle arithmetic.
module tb_fic_seq;
    import fic_seq_pkg::*;

    localparam int unsigned W    = 6;
    localparam int          NMAX = 39;

    logic clk_sys = 1'b0;
    logic rst;
    always #5 clk_sys = ~clk_sys;

    fic_seq_if #(.WIDTH(W)) bus ();

    fic_seq #(.WIDTH(W), .NORM_MAX(W'(NMAX))) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus)
    );

    // FIC counter (clr > load > dec > inc) and mantissa shift register
    logic [W-1:0] fic = '0;
    logic [47:0]  mant = '0;
    logic [47:0]  mant_init;
    logic         mant_load;
    logic         no_norm;

    always @(posedge clk_sys) begin
        if (bus.fic_clr)       fic <= '0;
        else if (bus.fic_load) fic <= bus.fic_in;
        else if (bus.fic_dec)  fic <= fic - 1'b1;
        else if (bus.fic_inc)  fic <= fic + 1'b1;
    end

    always @(posedge clk_sys) begin
        if (mant_load)     mant <= mant_init;
        else if (bus.shl)  mant <= mant << 1;
        else if (bus.shr)  mant <= 48'($signed(mant) >>> 1);
    end

    assign bus.fic_val = fic;
    assign bus.norm_ok = !no_norm && (mant[47] != mant[46]);
    assign bus.m_zero  = (mant == '0);

    int n_shr = 0, n_shl = 0, n_dec = 0, n_inc = 0, n_viol = 0;
    always @(posedge clk_sys) begin
        n_shr <= n_shr + (bus.shr ? 1 : 0);
        n_shl <= n_shl + (bus.shl ? 1 : 0);
        n_dec <= n_dec + (bus.fic_dec ? 1 : 0);
        n_inc <= n_inc + (bus.fic_inc ? 1 : 0);
        if ((bus.shr != bus.fic_dec) || (bus.shl != bus.fic_inc) ||
            ($countones({bus.fic_load, bus.fic_clr, bus.shr, bus.shl, bus.done}) > 1))
            n_viol <= n_viol + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {bus.fic_load, bus.fic_clr, bus.fic_dec, bus.fic_inc, bus.shr, bus.shl,
                bus.busy, bus.done, bus.zero, bus.limit, bus.fic_in};
    endfunction

    // Bits below the sign that equal the sign: the left shifts a NORM needs.
    function automatic int lead_cnt(input logic [47:0] m);
        int k = 0;
        for (int i = 46; i >= 0; i--) begin
            if (m[i] != m[47]) break;
            k++;
        end
        return k;
    endfunction

    task automatic do_op(input string tag, input logic op, input logic [W-1:0] c,
                         input logic [47:0] m, input logic hold, input logic poke);
        int steps, exp_cyc, lead, done_cyc;
        int s_shr, s_shl, s_dec, s_inc;
        logic ez, el;
        logic [W-1:0] ef;
        logic [47:0] em;

        ez = 1'b0;
        el = 1'b0;
        if (op == OP_ALIGN) begin
            steps = int'(c);
            ef    = '0;
            em    = 48'($signed(m) >>> c);
        end else begin
            lead = hold ? 48 : lead_cnt(m);
            if (m == '0) begin
                steps = 0;
                ez    = 1'b1;
            end else if (lead > NMAX) begin
                steps = NMAX;
                el    = 1'b1;
            end else begin
                steps = lead;
            end
            ef = W'(steps);
            em = m << steps;
        end
        exp_cyc = 2 * steps + 3;

        // cycle 0: request
        mant_init = m;
        mant_load = 1'b1;
        no_norm   = hold;
        bus.start = 1'b1;
        bus.op    = op;
        bus.cnt   = c;
        s_shr = n_shr; s_shl = n_shl; s_dec = n_dec; s_inc = n_inc;
        @(posedge clk_sys); #1;
        mant_load = 1'b0;
        bus.start = 1'b0;
        bus.cnt   = W'($urandom);
        check({tag, "_busy1"}, 64'(bus.busy), 64'd1);
        check({tag, "_ldclr"}, 64'({bus.fic_load, bus.fic_clr}), (op == OP_ALIGN) ? 64'd2 : 64'd1);
        check({tag, "_fic_in"}, 64'(bus.fic_in), 64'(c));
        check({tag, "_zl_clr"}, 64'({bus.zero, bus.limit}), 64'd0);

        done_cyc = -1;
        for (int n = 1; n <= 200; n++) begin
            if (poke && (n == 3 || n == exp_cyc)) begin
                bus.start = 1'b1;
                bus.op    = ~op;
                bus.cnt   = W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                done_cyc = n;
                break;
            end
            @(posedge clk_sys); #1;
        end

        check({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_cyc));
        check({tag, "_zero"}, 64'(bus.zero), 64'(ez));
        check({tag, "_limit"}, 64'(bus.limit), 64'(el));
        check({tag, "_fic_val"}, 64'(bus.fic_val), 64'(ef));
        check({tag, "_mant"}, 64'(mant), 64'(em));
        check({tag, "_shr"}, 64'(n_shr - s_shr), (op == OP_ALIGN) ? 64'(steps) : 64'd0);
        check({tag, "_shl"}, 64'(n_shl - s_shl), (op == OP_NORM) ? 64'(steps) : 64'd0);
        check({tag, "_dec_inc"}, 64'((n_dec - s_dec) + (n_inc - s_inc)), 64'(steps));

        @(posedge clk_sys); #1;
        bus.start = 1'b0;
        check({tag, "_after"}, 64'({bus.busy, bus.done, bus.zero, bus.limit}), 64'({2'b00, ez, el}));
    endtask

    initial begin
        logic [47:0] m;
        logic [W-1:0] c;
        logic op;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_ALIGN;
        bus.cnt   = '0;
        mant_load = 1'b0;
        mant_init = '0;
        no_norm   = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        check("reset_outs", 64'(outs()), 64'd0);
        rst = 1'b0;
        @(posedge clk_sys); #1;
        check("idle_outs", 64'(outs()), 64'd0);

        do_op("align5",     OP_ALIGN, 6'd5, 48'h1234_5678_9abc, 1'b0, 1'b0);
        do_op("align0",     OP_ALIGN, 6'd0, 48'h8000_0000_0001, 1'b0, 1'b0);
        do_op("norm3",      OP_NORM,  6'd0, 48'h0800_0000_0000, 1'b0, 1'b0);
        do_op("norm_neg",   OP_NORM,  6'd0, 48'hFC00_0000_1234, 1'b0, 1'b0);
        do_op("norm_zero",  OP_NORM,  6'd0, 48'h0,              1'b0, 1'b0);
        do_op("norm_limit", OP_NORM,  6'd0, 48'h1,              1'b1, 1'b0);
        do_op("poke",       OP_ALIGN, 6'd4, 48'hF0F0_1234_5678, 1'b0, 1'b1);
        do_op("b2b",        OP_NORM,  6'd7, 48'h0040_0000_0000, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            op = 1'($urandom_range(0, 1));
            c  = W'($urandom_range(0, 20));
            m  = 48'({$urandom, $urandom}) >> $urandom_range(0, 47);
            if ($urandom_range(0, 1) == 1) m = ~m;
            do_op($sformatf("rnd%0d", i), op, c, m, 1'b0, 1'b0);
        end

        // reset in the middle of an ALIGN, during a shift cycle
        mant_init = 48'h7777_0000_1111;
        mant_load = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_ALIGN;
        bus.cnt   = 6'd10;
        @(posedge clk_sys); #1;
        mant_load = 1'b0;
        bus.start = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        check("rst_pre_step", 64'(bus.shr), 64'd1);
        rst = 1'b1;
        @(posedge clk_sys); #1;
        check("rst_outs", 64'(outs()), 64'd0);
        rst = 1'b0;
        @(posedge clk_sys); #1;
        check("rst_idle", 64'(outs()), 64'd0);
        do_op("align2_post_rst", OP_ALIGN, 6'd2, 48'h0123_4567_89ab, 1'b0, 1'b0);

        check("strobe_excl", 64'(n_viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
